// File: rtl/matrix_ascii_streamer.sv
// matrix_ascii_streamer: snapshots a matrix and streams it as decimal ASCII text over a uart_tx byte handshake
module matrix_ascii_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM = 5,
  parameter int SIGNED = 0,
  localparam int DW = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [DW-1:0]                         matrix_row,
  input  logic [DW-1:0]                         matrix_col,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] data_flat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [7:0]                            tx_data,
  output logic                                  tx_start,
  input  logic                                  tx_busy
);
  function automatic int calc_ndig(int w);
    longint m;
    int n;
    m = (longint'(1) << w) - 1;
    n = 0;
    while (m > 0) begin
      m = m / 10;
      n++;
    end
    return n;
  endfunction
  localparam int NDIG = calc_ndig(DATA_WIDTH);
  localparam logic [DW-1:0] MD = DW'(MAX_DIM);
  typedef enum logic [2:0] {IDLE, CHECK, CONV, SEND, WAIT_ACK, WAIT_DONE, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] rows, cols, r, c, nr, nc;
  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0] mag, elem, elem_mag;
  logic [4*NDIG-1:0] bcd, bcd_adj;
  logic neg, elem_neg, bad, last_col, last_elem, lead;
  logic [4:0] cnt;
  logic [3:0] idx, q_len, dig;
  logic [7:0] q [16];
  assign bad = rows == '0 || cols == '0 || rows > MD || cols > MD;
  assign last_col = c == cols - 1'b1;
  assign last_elem = last_col && r == rows - 1'b1;
  // CHECK loads element (0,0); NEXT loads the element it is advancing to
  assign nc = (state == NEXT && !last_col) ? c + 1'b1 : '0;
  assign nr = state != NEXT ? '0 : last_col ? r + 1'b1 : r;
  assign elem = snap[(int'(nr) * MAX_DIM + int'(nc)) * DATA_WIDTH +: DATA_WIDTH];
  assign elem_neg = SIGNED != 0 && elem[DATA_WIDTH-1];
  assign elem_mag = elem_neg ? -elem : elem;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // Text of the current element: sign, digits without leading zeros, separator
  always_comb begin
    for (int i = 0; i < 16; i++) q[i] = 8'h00;
    q_len = '0;
    lead = 1'b1;
    dig = '0;
    if (neg) begin
      q[0] = 8'h2D;
      q_len = 4'd1;
    end
    for (int i = NDIG - 1; i >= 0; i--) begin
      dig = bcd[4*i +: 4];
      if (dig != 4'd0 || !lead || i == 0) begin
        q[q_len] = {4'h3, dig};
        q_len = q_len + 4'd1;
        lead = 1'b0;
      end
    end
    if (last_col) begin
      q[q_len] = 8'h0D;
      q[q_len + 4'd1] = 8'h0A;
      q_len = q_len + 4'd2;
    end else begin
      q[q_len] = 8'h20;
      q_len = q_len + 4'd1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? CHECK : IDLE;
      CHECK:     state_n = bad ? IDLE : CONV;
      CONV:      state_n = cnt == 5'(DATA_WIDTH - 1) ? SEND : CONV;
      SEND:      state_n = tx_busy ? SEND : WAIT_ACK;
      WAIT_ACK:  state_n = WAIT_DONE;
      WAIT_DONE: state_n = tx_busy ? WAIT_DONE : idx < q_len ? SEND : NEXT;
      NEXT:      state_n = last_elem ? DONE : CONV;
      default:   state_n = IDLE;
    endcase
  end
  assign busy = !(state == IDLE || state == DONE || (state == CHECK && bad));
  assign done = state == DONE;
  assign err = state == CHECK && bad;
  assign tx_start = state == SEND && !tx_busy;
  assign tx_data = state == SEND ? q[idx] : 8'h00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rows <= '0;
      cols <= '0;
      snap <= '0;
      r <= '0;
      c <= '0;
      mag <= '0;
      neg <= 1'b0;
      bcd <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        rows <= matrix_row;
        cols <= matrix_col;
        snap <= data_flat;
      end
      if (state == CHECK || state == NEXT) begin
        r <= nr;
        c <= nc;
        mag <= elem_mag;
        neg <= elem_neg;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == CONV) begin
        bcd <= {bcd_adj[4*NDIG-2:0], mag[DATA_WIDTH-1]};
        mag <= mag << 1;
        cnt <= cnt + 1'b1;
        idx <= '0;
      end
      if (state == SEND && !tx_busy) idx <= idx + 1'b1;
    end
  end
endmodule
